// File: rtl/ms_pkg.sv
// Shared definitions for the multiply_sum feeder path: FSM state encoding and width defaults.
package ms_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int B_W_DEF        = 16;
  localparam int FRAME_LEN_DEF  = 16;
  localparam int MS_LATENCY_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } ms_state_e;

endpackage

// File: rtl/ms_valid_delay.sv
// Generic WIDTH x DEPTH registered shift line with synchronous clear.
module ms_valid_delay #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign data_o = sr_q[DEPTH-1];

endmodule

// File: rtl/ms_window_feeder.sv
// Turns a framed sample stream into 3-tap centred windows (edge replication) for multiply_sum,
// and delays the window qualifiers by the multiply_sum latency.
module ms_window_feeder
  import ms_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int B_W        = B_W_DEF,
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int MS_LATENCY = MS_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [B_W-1:0]    b_cfg_i,
  output logic [B_W-1:0]    b_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] data3_o,
  output logic              win_valid,
  output logic              sum_valid,
  output logic              sum_last,
  output ms_state_e         dbg_state_o
);

  localparam int CNT_W = $clog2(FRAME_LEN);

  // Handshake: a sample transfers on a rising edge where in_valid & in_ready are both high;
  // in_ready depends only on state and rst, never on in_valid.

  ms_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hist0_q, hist0_d;
  logic [DATA_W-1:0] hist1_q, hist1_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [B_W-1:0]    b_q, b_d;
  logic              wv_q, wv_d, wl_q, wl_d;
  logic              accept;
  logic              last_sample;
  logic [1:0]        dly_out;

  assign in_ready    = (state_q != ST_FLUSH) & ~rst;
  assign accept      = in_valid & in_ready;
  // cnt_q holds the index of the most recently accepted sample of the frame
  assign last_sample = (cnt_q == CNT_W'(FRAME_LEN - 2));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hist0_d = hist0_q;
    hist1_d = hist1_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    b_d     = b_q;
    wv_d    = 1'b0;
    wl_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          hist0_d = in_data;
          b_d     = b_cfg_i;
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL, ST_RUN: begin
        if (accept) begin
          // The first window replicates x0 into the leading tap
          d1_d    = (state_q == ST_FILL) ? hist0_q : hist1_q;
          d2_d    = hist0_q;
          d3_d    = in_data;
          wv_d    = 1'b1;
          hist1_d = hist0_q;
          hist0_d = in_data;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = last_sample ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        d1_d    = hist1_q;
        d2_d    = hist0_q;
        d3_d    = hist0_q;
        wv_d    = 1'b1;
        wl_d    = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hist0_q <= '0;
      hist1_q <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      b_q     <= '0;
      wv_q    <= 1'b0;
      wl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hist0_q <= hist0_d;
      hist1_q <= hist1_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      b_q     <= b_d;
      wv_q    <= wv_d;
      wl_q    <= wl_d;
    end
  end

  ms_valid_delay #(
    .WIDTH(2),
    .DEPTH(MS_LATENCY)
  ) u_sum_delay (
    .clk   (clk),
    .rst   (rst),
    .data_i({wv_q, wl_q}),
    .data_o(dly_out)
  );

  assign data1_o     = d1_q;
  assign data2_o     = d2_q;
  assign data3_o     = d3_q;
  assign b_o         = b_q;
  assign win_valid   = wv_q;
  assign sum_valid   = dly_out[1];
  assign sum_last    = dly_out[0];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ms_window_feeder.sv
// Directed bench for ms_window_feeder with a frame-level reference model checked every cycle.
module tb_ms_window_feeder;

  localparam int DW = 32;
  localparam int BW = 16;
  localparam int N  = 4;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [BW-1:0] b_cfg_i;
  logic [BW-1:0] b_o;
  logic [DW-1:0] data1_o, data2_o, data3_o;
  logic          win_valid, sum_valid, sum_last;
  ms_pkg::ms_state_e dbg_state;

  ms_window_feeder #(
    .DATA_W(DW), .B_W(BW), .FRAME_LEN(N), .MS_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .b_cfg_i(b_cfg_i), .b_o(b_o), .data1_o(data1_o), .data2_o(data2_o), .data3_o(data3_o),
    .win_valid(win_valid), .sum_valid(sum_valid), .sum_last(sum_last), .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-frame sample array, windows derived from index clamping
  logic [DW-1:0] fx [N];
  int            mcnt = 0;
  bit            flushing = 1'b0;
  logic          e_wv = 1'b0, e_wl = 1'b0;
  logic [DW-1:0] e_d1 = '0, e_d2 = '0, e_d3 = '0;
  logic [BW-1:0] e_b = '0;
  logic [1:0]    sv_q [$];
  logic [1:0]    e_s;
  logic [95:0]   obs_q [$];
  int            sv_cnt = 0;
  int            ready_low_cnt = 0;
  int            j;

  initial begin
    for (int i = 0; i < L; i++) sv_q.push_back(2'b00);
  end

  always @(negedge clk) begin
    chk("in_ready", {95'd0, in_ready}, {95'd0, (!rst && !flushing)});
    chk("win_valid", {95'd0, win_valid}, {95'd0, e_wv});
    chk("taps", {data1_o, data2_o, data3_o}, {e_d1, e_d2, e_d3});
    chk("b_o", {80'd0, b_o}, {80'd0, e_b});
    sv_q.push_back({e_wv, e_wl});
    e_s = sv_q.pop_front();
    chk("sum_valid", {95'd0, sum_valid}, {95'd0, e_s[1]});
    chk("sum_last", {95'd0, sum_last}, {95'd0, e_s[0]});
    if (win_valid) obs_q.push_back({data1_o, data2_o, data3_o});
    if (sum_valid) sv_cnt++;
    if (!in_ready && !rst) ready_low_cnt++;

    if (rst) begin
      e_wv = 0; e_wl = 0; e_d1 = '0; e_d2 = '0; e_d3 = '0; e_b = '0;
      mcnt = 0; flushing = 0;
      sv_q.delete();
      for (int i = 0; i < L; i++) sv_q.push_back(2'b00);
    end else begin
      e_wv = 0; e_wl = 0;
      if (flushing) begin
        e_wv = 1; e_wl = 1;
        e_d1 = fx[N-2]; e_d2 = fx[N-1]; e_d3 = fx[N-1];
        flushing = 0; mcnt = 0;
      end else if (in_valid && in_ready) begin
        fx[mcnt] = in_data;
        if (mcnt == 0) e_b = b_cfg_i;
        else begin
          j = mcnt - 1;
          e_wv = 1;
          e_d1 = fx[(j >= 1) ? j - 1 : 0];
          e_d2 = fx[j];
          e_d3 = fx[j + 1];
        end
        mcnt++;
        if (mcnt == N) flushing = 1;
      end
    end
  end

  // Drivers
  task automatic send(input logic [DW-1:0] x, input logic [BW-1:0] b);
    int t;
    in_valid = 1'b1;
    in_data  = x;
    b_cfg_i  = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 20) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no in_ready within 20 cycles expected accept");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_obs(input string name, input int idx, input logic [95:0] exp);
    if (idx < obs_q.size()) chk(name, obs_q[idx], exp);
    else chk(name, 96'hdead, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; b_cfg_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_taps", {data1_o, data2_o, data3_o}, 96'd0);
    rst = 1'b0;

    // 1: contiguous frame
    obs_q.delete(); sv_cnt = 0;
    send(10, 5); send(20, 5); send(30, 5); send(40, 5);
    idle(L + 4);
    chk("t1_count", obs_q.size(), 4);
    chk_obs("t1_w0", 0, {32'd10, 32'd10, 32'd20});
    chk_obs("t1_w1", 1, {32'd10, 32'd20, 32'd30});
    chk_obs("t1_w2", 2, {32'd20, 32'd30, 32'd40});
    chk_obs("t1_w3", 3, {32'd30, 32'd40, 32'd40});
    chk("t1_b", {80'd0, b_o}, 96'd5);
    chk("t1_sum_count", sv_cnt, 4);

    // 2: bubbles between samples
    obs_q.delete();
    send(10, 5); idle(2); send(20, 5); idle(2); send(30, 5); idle(2); send(40, 5); idle(L + 4);
    chk("t2_count", obs_q.size(), 4);
    chk_obs("t2_w0", 0, {32'd10, 32'd10, 32'd20});
    chk_obs("t2_w3", 3, {32'd30, 32'd40, 32'd40});

    // 3: back-to-back frames with in_valid held high
    obs_q.delete(); ready_low_cnt = 0;
    for (int i = 1; i <= 8; i++) send(i * 100, 7);
    idle(L + 4);
    chk("t3_ready_low", ready_low_cnt, 2);
    chk("t3_count", obs_q.size(), 8);
    chk_obs("t3_w4", 4, {32'd500, 32'd500, 32'd600});

    // 4: b_cfg_i changes mid-frame
    send(11, 5); send(12, 5); send(13, 9); send(14, 9);
    chk("t4_b_frame_a", {80'd0, b_o}, 96'd5);
    send(21, 9);
    chk("t4_b_frame_b", {80'd0, b_o}, 96'd9);
    send(22, 9); send(23, 9); send(24, 9); idle(L + 4);

    // 5: sign-extreme data
    obs_q.delete();
    send(32'hFFFF_FFFF, 16'h8001); send(32'hFFFF_FFFE, 16'h8001);
    send(32'h7FFF_FFFF, 16'h8001); send(32'h8000_0000, 16'h8001);
    idle(L + 4);
    chk_obs("t5_w0", 0, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    chk_obs("t5_w1", 1, {32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFF});
    chk_obs("t5_w3", 3, {32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000});
    chk("t5_b", {80'd0, b_o}, 96'h8001);

    // 6: reset mid-frame
    send(1, 3); send(2, 3); send(3, 3);
    in_valid = 1'b0; rst = 1'b1; sv_cnt = 0;
    @(posedge clk); #1;
    chk("t6_reset_out", {data1_o, data2_o, data3_o}, 96'd0);
    chk("t6_reset_b", {80'd0, b_o}, 96'd0);
    rst = 1'b0;
    idle(L + 3);
    chk("t6_no_sum", sv_cnt, 0);
    obs_q.delete();
    send(5, 4); send(6, 4); send(7, 4); send(8, 4); idle(L + 4);
    chk_obs("t6_fresh_w0", 0, {32'd5, 32'd5, 32'd6});
    chk_obs("t6_fresh_w3", 3, {32'd7, 32'd8, 32'd8});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
